// File: rtl/bus_mux_pkg.sv
// rtl/bus_mux_pkg.sv - shared types and one-hot helpers for the datapath bus muxes
package bus_mux_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    MODE_GATE = 1'b0,
    MODE_ARB  = 1'b1
  } mux_mode_t;

  // Callers zero-extend narrower select vectors to MAX_N bits.
  function automatic logic is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting the scan at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = '0;
    // Visit ptr, ptr+1, ... wrapping modulo N; the first requester found wins.
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr) + i) % N);
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - N-channel registered bus mux with one-hot gate or round-robin arbitration
module bus_arb_mux
  import bus_mux_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Mode,
  input  logic [N-1:0]         Gate,
  input  logic [N-1:0]         Req,
  input  logic [N*W-1:0]       Din,
  output logic [N-1:0]         Ack,
  output logic [W-1:0]         Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [$clog2(N)-1:0] Grant_Idx,
  output logic                 Err
);

  localparam int IW = $clog2(N);

  mux_mode_t        mode;
  logic             load;
  logic             capture;
  logic [MAX_N-1:0] gate_ext;
  logic             gate_onehot;
  logic             gate_any;
  logic             sel_valid;
  logic [N-1:0]     sel_oh;
  logic [IW-1:0]    sel_idx;
  logic [N-1:0]     arb_oh;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;

  assign mode        = mux_mode_t'(Mode);
  assign gate_ext    = MAX_N'(Gate);
  assign gate_onehot = is_onehot(gate_ext);
  assign gate_any    = (Gate != '0);

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req       (Req),
    .ptr       (ptr),
    .grant     (arb_oh),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_oh    = '0;
    sel_idx   = '0;
    if (mode == MODE_ARB) begin
      sel_valid = arb_any;
      sel_oh    = arb_oh;
      sel_idx   = arb_idx;
    end else begin
      sel_valid = gate_onehot;
      sel_oh    = Gate;
      sel_idx   = IW'(onehot_to_idx(gate_ext));
    end
  end

  // The output register can take a word when empty or when it is being drained this edge.
  assign load     = !Out_Valid || Out_Ready;
  assign capture  = !Reset && load && sel_valid;
  assign ptr_next = (arb_idx == IW'(N - 1)) ? '0 : arb_idx + 1'b1;

  assign Ack = capture ? sel_oh : '0;
  assign Err = !Reset && (mode == MODE_GATE) && gate_any && !gate_onehot;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out       <= '0;
      Out_Valid <= 1'b0;
      Grant_Idx <= '0;
      ptr       <= '0;
    end else if (capture) begin
      Out       <= Din[sel_idx*W +: W];
      Out_Valid <= 1'b1;
      Grant_Idx <= sel_idx;
      if (mode == MODE_ARB) ptr <= ptr_next;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - directed self-checking bench for bus_arb_mux
module tb_bus_arb_mux;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         mode;
  logic [N-1:0] gate;
  logic [N-1:0] req;
  logic [N*W-1:0] din;
  logic [N-1:0] ack;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   grant_idx;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] chan [N];
  int exp_seq [5];

  always #5 clk = ~clk;

  bus_arb_mux #(.W(W), .N(N)) dut (
    .Clk       (clk),
    .Reset     (reset),
    .Mode      (mode),
    .Gate      (gate),
    .Req       (req),
    .Din       (din),
    .Ack       (ack),
    .Out       (out),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Grant_Idx (grant_idx),
    .Err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    chan[0] = 16'h1111;
    chan[1] = 16'h2222;
    chan[2] = 16'hBEEF;
    chan[3] = 16'h4444;
    din = {chan[3], chan[2], chan[1], chan[0]};
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 3; exp_seq[4] = 0;

    reset = 1'b1; mode = 1'b0; gate = '0; req = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);

    // GATE single capture of ch2
    reset = 1'b0; gate = 4'b0100;
    #1;
    chk("gate_ack", ack, 4'b0100);
    chk("gate_err", err, 0);
    tick();
    chk("gate_out", out, 16'hBEEF);
    chk("gate_grant", grant_idx, 2);
    chk("gate_valid", out_valid, 1);

    // GATE multi-hot: error pulse, no capture, register drains
    gate = 4'b0110;
    #1;
    chk("gerr_err", err, 1);
    chk("gerr_ack", ack, 0);
    tick();
    chk("gerr_valid", out_valid, 0);
    chk("gerr_out", out, 16'hBEEF);
    gate = '0;
    #1;
    chk("gerr_pulse_end", err, 0);
    chk("gate_idle_ack", ack, 0);

    // ARB fairness with all requesting
    mode = 1'b1; req = 4'b1111; gate = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ack", ack, 32'(1) << exp_seq[i]);
      chk("arb_no_err", err, 0);
      tick();
      chk("rr_grant", grant_idx, exp_seq[i]);
      chk("rr_out", out, chan[exp_seq[i]]);
      chk("rr_valid", out_valid, 1);
    end
    gate = '0;

    // Reset mid-stream while stalled and requesting
    out_ready = 1'b0; reset = 1'b1;
    #1;
    chk("rst2_ack", ack, 0);
    tick(); tick();
    chk("rst2_out", out, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_grant", grant_idx, 0);
    chk("rst2_err", err, 0);

    // Back-pressure: ch0 captured, then held for 3 stalled cycles
    reset = 1'b0; out_ready = 1'b1; req = 4'b0011;
    #1;
    chk("bp_ack0", ack, 4'b0001);
    tick();
    chk("bp_out0", out, 16'h1111);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_ack", ack, 0);
      tick();
      chk("bp_hold_out", out, 16'h1111);
      chk("bp_hold_grant", grant_idx, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ack1", ack, 4'b0010);
    tick();
    chk("bp_out1", out, 16'h2222);
    chk("bp_grant1", grant_idx, 1);
    chk("bp_valid1", out_valid, 1);

    // Sparse/wrap: ptr=2 -> ch2 (ptr 3), then ch1 (ptr 2), then ch3 (ptr 0)
    req = 4'b0100;
    tick();
    chk("sp_grant2", grant_idx, 2);
    req = 4'b0010;
    #1;
    chk("sp_ack1", ack, 4'b0010);
    tick();
    chk("sp_grant1", grant_idx, 1);
    req = 4'b1000;
    #1;
    chk("sp_ack3", ack, 4'b1000);
    tick();
    chk("sp_grant3", grant_idx, 3);
    chk("sp_out3", out, 16'h4444);
    req = 4'b1111;
    #1;
    chk("wrap_ack0", ack, 4'b0001);
    tick();
    chk("wrap_grant0", grant_idx, 0);

    // No requests: register drains, nothing acknowledged
    req = '0;
    #1;
    chk("idle_ack", ack, 0);
    tick();
    chk("idle_valid", out_valid, 0);
    chk("idle_out", out, 16'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
